multi_servo: RTL and testbench
==============================

MULTI_SERVO -- requirements
Module: multi_servo

Interface
REQ-001 Parameter CLK_PER_NS, default 40: clock period in ns.
REQ-002 Parameter N, default 8: position width in bits.
REQ-003 Parameter CHANNELS, default 4: number of servo outputs, range 1..16.
REQ-004 Parameter FRAME_MS, default 20: frame period in ms.
REQ-005 Parameter RESET_POS, default 128: position loaded into every channel at reset.
REQ-006 Derived constants: BASE_CYC = 1_000_000/CLK_PER_NS; STEP_CYC = BASE_CYC >> N; FRAME_CYC = FRAME_MS*BASE_CYC; CW = max(1, $clog2(CHANNELS)).
REQ-007 clk_i  in  1  single clock; all logic is on its rising edge.
REQ-008 rst_i  in  1  reset, synchronous, active-high.
REQ-009 en_i  in  1  global enable; low forces all outputs low and holds the frame counter at 0.
REQ-010 ch_en_i  in  CHANNELS  per-channel output enable mask.
REQ-011 wr_i  in  1  position write strobe, one write per cycle, always accepted.
REQ-012 wr_ch_i  in  CW  target channel index for the write.
REQ-013 wr_pos_i  in  N  new position for the target channel.
REQ-014 srv_o  out  CHANNELS  registered servo pulse outputs.
REQ-015 frame_o  out  1  registered one-cycle pulse marking the first cycle of each frame.

Function
REQ-016 Frame counter: $clog2(FRAME_CYC) bits; counts 0..FRAME_CYC-1 while en_i=1, then wraps to 0.
REQ-017 Each channel has a shadow register and an active register, both N bits.
REQ-018 Write: wr_i=1 with wr_ch_i<CHANNELS updates shadow[wr_ch_i] at the next edge.
REQ-019 Write: wr_ch_i>=CHANNELS is ignored with no side effect.
REQ-020 Writes are legal on any cycle, including while en_i=0.
REQ-021 Frame load: when the frame counter is 0, every active register is loaded from its shadow register.
REQ-022 A write in the same cycle as a frame load is not seen by that load; it takes effect at the next frame.
REQ-023 Active registers never change mid-frame, so every pulse is glitch-free and complete.
REQ-024 Pulse width: PW[c] = BASE_CYC + active[c]*STEP_CYC clock cycles, computed at frame-counter width with no truncation.
REQ-025 srv_o[c] is high for exactly PW[c] consecutive cycles per frame, starting in the cycle where frame_o=1, then low for the rest of the frame.
REQ-026 frame_o and all srv_o rising edges of a frame occur in the same cycle; latency from frame counter=0 to that cycle is 1 cycle.
REQ-027 srv_o[c] is forced low whenever ch_en_i[c]=0 (registered, 1-cycle latency); the frame counter keeps running.
REQ-028 ch_en_i[c] rising mid-frame keeps srv_o[c] low until the next frame start, so no partial pulse is emitted.
REQ-029 en_i falling: next cycle, frame counter=0, all srv_o=0, frame_o=0; shadow and active registers are retained.
REQ-030 en_i rising: the frame counter starts at 0 in that cycle; the frame load and frame_o follow per REQ-021/026.
REQ-031 Elaboration error is raised if BASE_CYC + (2^N-1)*STEP_CYC >= FRAME_CYC or STEP_CYC==0.

Reset
REQ-032 rst_i=1 at an edge sets: frame counter=0; all shadow and active registers=RESET_POS; srv_o=0; frame_o=0.
REQ-033 rst_i takes priority over en_i and wr_i.
REQ-034 Reset asserted mid-pulse drives srv_o low at the next edge.
REQ-035 After reset is released with en_i=1, the first frame_o occurs 1 cycle after the first counter=0 cycle.

Verification (defaults: BASE_CYC=25000, STEP_CYC=97, FRAME_CYC=500000)
REQ-036 Reset, en_i=1, ch_en_i=4'hF, no writes -> each srv_o high 37416 cycles; frame_o period 500000 cycles.
REQ-037 Write ch2 pos 0 and ch3 pos 255 mid-frame -> current frame unchanged; next frame ch2 high 25000 cycles, ch3 high 49735 cycles.
REQ-038 Write ch1 pos 10 in the exact frame-load cycle -> ch1 keeps its old width this frame; next frame ch1 high 25970 cycles.
REQ-039 Deassert en_i 100 cycles into a pulse -> srv_o=0 next cycle; reassert en_i -> frame_o and full-width pulses restart with no partial pulse.
REQ-040 ch_en_i[0] 0->1 mid-frame -> srv_o[0] low until the next frame_o; wr_ch_i=5 with CHANNELS=4 -> no register changes.
REQ-041 Assert rst_i mid-pulse with channels at pos 200 -> srv_o=0 next cycle; afterwards all channels produce 37416-cycle pulses.

Source files
------------

// File: rtl/multi_servo_if.sv
// rtl/multi_servo_if.sv - position write bus carrying channel index and new position
// Signals:
//   wr_i      write strobe, one write per cycle, always accepted
//   wr_ch_i   target channel index (indices >= CHANNELS are dropped by the slave)
//   wr_pos_i  new position for the target channel
// Modports: master drives the bus, slave (multi_servo) samples it.
interface multi_servo_if #(
    parameter int N  = 8,
    parameter int CW = 2
);
    logic          wr_i;
    logic [CW-1:0] wr_ch_i;
    logic [N-1:0]  wr_pos_i;

    modport master (output wr_i, wr_ch_i, wr_pos_i);
    modport slave  (input  wr_i, wr_ch_i, wr_pos_i);
endinterface

// File: rtl/multi_servo.sv
// rtl/multi_servo.sv - multi-channel servo PWM generator with double-buffered positions
// Ports:
//   clk_i    single clock, rising edge
//   rst_i    synchronous active-high reset
//   en_i     global enable; low holds the frame counter at 0 and forces outputs low
//   ch_en_i  per-channel output enable mask
//   wr_if    position write bus (slave modport)
//   srv_o    registered servo pulse outputs
//   frame_o  registered one-cycle pulse on the first cycle of each frame
module multi_servo #(
    parameter int CLK_PER_NS = 40,
    parameter int N          = 8,
    parameter int CHANNELS   = 4,
    parameter int FRAME_MS   = 20,
    parameter int RESET_POS  = 128
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [CHANNELS-1:0] ch_en_i,
    multi_servo_if.slave        wr_if,
    output logic [CHANNELS-1:0] srv_o,
    output logic                frame_o
);
    localparam int BASE_CYC  = 1_000_000 / CLK_PER_NS;
    localparam int STEP_CYC  = BASE_CYC >> N;
    localparam int FRAME_CYC = FRAME_MS * BASE_CYC;
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FW        = $clog2(FRAME_CYC);
    localparam longint MAX_PW = longint'(BASE_CYC)
                              + ((longint'(1) << N) - 1) * longint'(STEP_CYC);

    localparam logic [FW-1:0] BASE_W  = FW'(BASE_CYC);
    localparam logic [FW-1:0] STEP_W  = FW'(STEP_CYC);
    localparam logic [FW-1:0] LAST_W  = FW'(FRAME_CYC - 1);
    localparam logic [N-1:0]  RESET_W = N'(RESET_POS);

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("multi_servo: CHANNELS must be within 1..16");
    end
    if (STEP_CYC == 0 || MAX_PW >= longint'(FRAME_CYC)) begin : g_bad_timing
        $error("multi_servo: widest pulse does not fit in the frame, or step is zero");
    end

    logic [FW-1:0]       cnt_q, cnt_d;
    logic [N-1:0]        shadow_q [CHANNELS];
    logic [N-1:0]        shadow_d [CHANNELS];
    logic [N-1:0]        active_q [CHANNELS];
    logic [N-1:0]        active_d [CHANNELS];
    logic [CHANNELS-1:0] srv_q, srv_d;
    logic                frame_q, frame_d;
    logic [FW-1:0]       pw [CHANNELS];
    logic                frame_start;

    always_comb begin
        frame_start = en_i && (cnt_q == '0);

        cnt_d = '0;
        if (en_i && (cnt_q != LAST_W)) begin
            cnt_d = cnt_q + FW'(1);
        end

        frame_d = frame_start;
        srv_d   = '0;

        for (int c = 0; c < CHANNELS; c++) begin
            // Indices with no matching channel simply never hit, so out-of-range writes vanish.
            shadow_d[c] = shadow_q[c];
            if (wr_if.wr_i && (wr_if.wr_ch_i == CW'(c))) begin
                shadow_d[c] = wr_if.wr_pos_i;
            end

            // The load reads the pre-edge shadow, so a same-cycle write waits a frame.
            active_d[c] = frame_start ? shadow_q[c] : active_q[c];

            pw[c] = BASE_W + FW'(active_q[c]) * STEP_W;

            // A pulse can only begin at frame start and only continues while it is
            // already high, so a channel re-enabled mid-frame stays low until the next frame.
            if (!en_i || !ch_en_i[c]) begin
                srv_d[c] = 1'b0;
            end else if (cnt_q == '0) begin
                srv_d[c] = 1'b1;
            end else begin
                srv_d[c] = srv_q[c] && (cnt_q < pw[c]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            srv_q   <= '0;
            frame_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= RESET_W;
                active_q[c] <= RESET_W;
            end
        end else begin
            cnt_q    <= cnt_d;
            srv_q    <= srv_d;
            frame_q  <= frame_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign srv_o   = srv_q;
    assign frame_o = frame_q;
endmodule

// File: tb/tb_multi_servo.sv
// tb/tb_multi_servo.sv - randomized scoreboard bench for multi_servo
module tb_multi_servo;
    localparam int CLK_PER_NS = 10000;
    localparam int N          = 4;
    localparam int CHANNELS   = 5;
    localparam int FRAME_MS   = 3;
    localparam int RESET_POS  = 8;
    localparam int CW         = 3;
    localparam int BASE       = 1000000 / CLK_PER_NS;
    localparam int STEP       = BASE >> N;
    localparam int F          = FRAME_MS * BASE;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [CHANNELS-1:0] ch_en;
    logic [CHANNELS-1:0] srv;
    logic                frame;

    multi_servo_if #(.N(N), .CW(CW)) wr_bus ();

    multi_servo #(
        .CLK_PER_NS(CLK_PER_NS),
        .N(N),
        .CHANNELS(CHANNELS),
        .FRAME_MS(FRAME_MS),
        .RESET_POS(RESET_POS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .en_i(en),
        .ch_en_i(ch_en),
        .wr_if(wr_bus),
        .srv_o(srv),
        .frame_o(frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     ch;
        longint start;
        longint width;
    } pulse_t;

    pulse_t exp_pulses[$];
    longint exp_frames[$];
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    int     frames_expected = 0;
    int     frames_seen = 0;
    int     pulses_expected = 0;
    int     pulses_seen = 0;

    // Reference model: frames are anchored to the cycle the run (re)started and recur every F
    // cycles; each pulse is an interval [start, start+PW-1] that a disable, reset or channel
    // mask drop cuts short.
    int     shadow_m [CHANNELS];
    int     active_m [CHANNELS];
    bit     running = 1'b0;
    longint origin = 0;
    bit     pending [CHANNELS];
    longint p_start [CHANNELS];
    longint p_last  [CHANNELS];

    task automatic finish_pulse(input int c, input longint last);
        pulse_t p;
        p.ch    = c;
        p.start = p_start[c];
        p.width = last - p_start[c] + 1;
        exp_pulses.push_back(p);
        pulses_expected++;
        pending[c] = 1'b0;
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (pending[c]) begin
                if (rst || !en || !ch_en[c]) finish_pulse(c, cyc - 1);
                else if (cyc == p_last[c] + 1) finish_pulse(c, p_last[c]);
            end
        end
        if (rst) begin
            running = 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_m[c] = RESET_POS;
                active_m[c] = RESET_POS;
            end
        end else if (!en) begin
            running = 1'b0;
        end else begin
            if (!running) begin
                running = 1'b1;
                origin  = cyc;
            end
            if ((cyc - origin) % F == 0) begin
                exp_frames.push_back(cyc);
                frames_expected++;
                for (int c = 0; c < CHANNELS; c++) begin
                    active_m[c] = shadow_m[c];
                    if (ch_en[c]) begin
                        pending[c] = 1'b1;
                        p_start[c] = cyc;
                        p_last[c]  = cyc + BASE + active_m[c] * STEP - 1;
                    end
                end
            end
        end
        if (!rst && wr_bus.wr_i && int'(wr_bus.wr_ch_i) < CHANNELS)
            shadow_m[wr_bus.wr_ch_i] = int'(wr_bus.wr_pos_i);
    end

    task automatic check_pulse(input int c, input longint start, input longint width);
        int idx = -1;
        pulses_seen++;
        for (int i = 0; i < exp_pulses.size(); i++) begin
            if (idx < 0 && exp_pulses[i].ch == c) idx = i;
        end
        checks++;
        if (idx < 0) begin
            failures++;
            $display("FAIL pulse_unexpected ch=%0d start=%0d width=%0d required=none", c, start, width);
        end else begin
            if (exp_pulses[idx].start != start || exp_pulses[idx].width != width) begin
                failures++;
                $display("FAIL pulse ch=%0d actual start=%0d width=%0d required start=%0d width=%0d",
                         c, start, width, exp_pulses[idx].start, exp_pulses[idx].width);
            end
            exp_pulses.delete(idx);
        end
    endtask

    task automatic check_frame(input longint at);
        longint want;
        frames_seen++;
        checks++;
        if (exp_frames.size() == 0) begin
            failures++;
            $display("FAIL frame_unexpected actual cycle=%0d required=none", at);
        end else begin
            want = exp_frames.pop_front();
            if (want != at) begin
                failures++;
                $display("FAIL frame actual cycle=%0d required cycle=%0d", at, want);
            end
        end
    endtask

    logic [CHANNELS-1:0] prev_srv = '0;
    longint              m_start [CHANNELS];

    always @(negedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (srv[c] === 1'b1 && !prev_srv[c]) m_start[c] = cyc;
            else if (srv[c] !== 1'b1 && prev_srv[c]) check_pulse(c, m_start[c], cyc - m_start[c]);
        end
        for (int c = 0; c < CHANNELS; c++) prev_srv[c] = (srv[c] === 1'b1);
        if (frame === 1'b1) check_frame(cyc);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int ch, input int pos);
        wr_bus.wr_i     = 1'b1;
        wr_bus.wr_ch_i  = CW'(ch);
        wr_bus.wr_pos_i = N'(pos);
        step(1);
        wr_bus.wr_i = 1'b0;
    endtask

    // Advance until the current cycle is the one whose closing edge loads a new frame.
    task automatic wait_load();
        for (int i = 0; i < F && ((cyc + 1 - origin) % F) != 0; i++) step(1);
    endtask

    task automatic expect_low(input string name);
        @(negedge clk);
        checks++;
        if (srv !== '0 || frame !== 1'b0) begin
            failures++;
            $display("FAIL %s actual srv=%b frame=%b required srv=0 frame=0", name, srv, frame);
        end
    endtask

    initial begin
        int off_left;
        rst = 1'b1;
        en = 1'b1;
        ch_en = '1;
        wr_bus.wr_i = 1'b0;
        wr_bus.wr_ch_i = '0;
        wr_bus.wr_pos_i = '0;
        step(3);
        expect_low("reset_state");
        step(1);
        rst = 1'b0;
        step(2 * F + 10);

        // mid-frame writes at both position extremes
        do_write(2, 0);
        do_write(3, 15);
        do_write(4, int'($urandom_range(15)));
        step(2 * F);

        // write landing on the exact frame-load cycle
        wait_load();
        do_write(1, 10);
        step(2 * F);

        // out-of-range channel writes
        do_write(5, 3);
        do_write(7, 0);
        do_write(6, 15);
        step(F);

        // global disable mid-pulse, write while disabled, re-enable
        wait_load();
        step(51);
        en = 1'b0;
        step(1);
        expect_low("en_fall");
        step(1);
        do_write(0, 5);
        step(20);
        en = 1'b1;
        step(2 * F);

        // channel mask drop mid-pulse and rise mid-frame; ch4 masked over a frame start
        ch_en[4] = 1'b0;
        wait_load();
        step(30);
        ch_en[0] = 1'b0;
        step(40);
        ch_en[0] = 1'b1;
        ch_en[4] = 1'b1;
        step(2 * F);

        // reset mid-pulse with all channels at a high position
        for (int c = 0; c < CHANNELS; c++) do_write(c, 12);
        step(F);
        wait_load();
        step(60);
        rst = 1'b1;
        step(1);
        expect_low("reset_mid_pulse");
        step(2);
        rst = 1'b0;
        step(2 * F);

        // randomized traffic
        off_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) begin
                wr_bus.wr_i     = 1'b1;
                wr_bus.wr_ch_i  = CW'($urandom_range(7));
                wr_bus.wr_pos_i = N'($urandom_range(15));
            end else begin
                wr_bus.wr_i = 1'b0;
            end
            if ($urandom_range(499) == 0) ch_en = CHANNELS'($urandom);
            if (off_left > 0) begin
                off_left--;
                if (off_left == 0) en = 1'b1;
            end else if ($urandom_range(1499) == 0) begin
                en = 1'b0;
                off_left = int'($urandom_range(40, 1));
            end
            rst = ($urandom_range(2999) == 0);
            step(1);
        end
        wr_bus.wr_i = 1'b0;
        rst = 1'b0;
        en = 1'b1;
        ch_en = '1;
        step(2 * F);

        // drain so every in-flight pulse closes
        en = 1'b0;
        step(3);
        @(negedge clk);
        checks++;
        if (exp_pulses.size() != 0) begin
            failures++;
            $display("FAIL pulses_left actual=%0d required=0", exp_pulses.size());
        end
        checks++;
        if (exp_frames.size() != 0) begin
            failures++;
            $display("FAIL frames_left actual=%0d required=0", exp_frames.size());
        end
        checks++;
        if (frames_seen != frames_expected) begin
            failures++;
            $display("FAIL frame_count actual=%0d required=%0d", frames_seen, frames_expected);
        end
        checks++;
        if (pulses_seen != pulses_expected) begin
            failures++;
            $display("FAIL pulse_count actual=%0d required=%0d", pulses_seen, pulses_expected);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
